// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty generator family.
// Contents: default counter modulus/width and the duty value type.
// Imported by pwm_period_counter and pwm_duty_gen.
package pwm_pkg;

   localparam int PERIOD_DEFAULT = 14;
   localparam int CW_DEFAULT     = 4;

   // Duty / count value at the default width.
   typedef logic [CW_DEFAULT-1:0] duty_t;

endpackage : pwm_pkg

// File: rtl/pwm_period_counter.sv
// Free-running mod-PERIOD counter with enable, synchronous active-high reset
// and a wrap flag; also exposes the next-state count for registered compares.
// Ports: clk, reset, en_i (count enable), count_o, count_nxt_o, wrap_o.
module pwm_period_counter
   import pwm_pkg::*;
#(
   parameter int PERIOD = PERIOD_DEFAULT,
   parameter int CW     = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic [CW-1:0] count_nxt_o,
   output logic          wrap_o
);

   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Wrap only counts when the counter is actually advancing.
   assign wrap_o = en_i & (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = wrap_o ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o     = count_q;
   assign count_nxt_o = count_d;

endmodule : pwm_period_counter

// File: rtl/pwm_duty_gen.sv
// Variable-duty PWM generator: mod-PERIOD counter compared against a
// double-buffered duty register; new duty values take effect at a period boundary.
// Ports: clk, reset (sync, active-high), w (count enable), duty_in/duty_load
// (duty request + strobe), pwm_out, count, period_end, duty_pending.
// Build option: PWM_POLARITY_INV_EN inverts pwm_out and makes its idle level high.
module pwm_duty_gen
   import pwm_pkg::*;
#(
   parameter int PERIOD = PERIOD_DEFAULT,
   parameter int CW     = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          w,
   input  logic [CW-1:0] duty_in,
   input  logic          duty_load,
   output logic          pwm_out,
   output logic [CW-1:0] count,
   output logic          period_end,
   output logic          duty_pending
);

   localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);

`ifdef PWM_POLARITY_INV_EN
   localparam logic PWM_IDLE = 1'b1;
`else
   localparam logic PWM_IDLE = 1'b0;
`endif

   logic [CW-1:0] count_nxt;
   logic          wrap;

   logic [CW-1:0] duty_active_q, duty_active_d;
   logic [CW-1:0] duty_shadow_q, duty_shadow_d;
   logic          duty_pending_q, duty_pending_d;
   logic          pwm_q, pwm_d;
   logic          period_end_q, period_end_d;
   logic [CW-1:0] dclamp;
   logic          on_cmp;

   pwm_period_counter #(
      .PERIOD (PERIOD),
      .CW     (CW)
   ) u_counter (
      .clk         (clk),
      .reset       (reset),
      .en_i        (w),
      .count_o     (count),
      .count_nxt_o (count_nxt),
      .wrap_o      (wrap)
   );

   // Anything above a full period means "always on".
   assign dclamp = (duty_in > PERIOD_C) ? PERIOD_C : duty_in;

   always_comb begin
      duty_active_d  = duty_active_q;
      duty_shadow_d  = duty_shadow_q;
      duty_pending_d = duty_pending_q;
      if (wrap) begin
         // A load coinciding with the boundary bypasses the shadow.
         if (duty_load) begin
            duty_active_d = dclamp;
         end else if (duty_pending_q) begin
            duty_active_d = duty_shadow_q;
         end
         duty_pending_d = 1'b0;
      end else if (duty_load) begin
         duty_shadow_d  = dclamp;
         duty_pending_d = 1'b1;
      end
   end

   // Compare on next-state values so the registered output lines up with
   // count. With w=0 both operands hold, so the output holds without a
   // separate enable.
   assign on_cmp = (count_nxt < duty_active_d);

`ifdef PWM_POLARITY_INV_EN
   assign pwm_d = ~on_cmp;
`else
   assign pwm_d = on_cmp;
`endif

   assign period_end_d = wrap;

   always_ff @(posedge clk) begin
      if (reset) begin
         duty_active_q  <= '0;
         duty_shadow_q  <= '0;
         duty_pending_q <= 1'b0;
         pwm_q          <= PWM_IDLE;
         period_end_q   <= 1'b0;
      end else begin
         duty_active_q  <= duty_active_d;
         duty_shadow_q  <= duty_shadow_d;
         duty_pending_q <= duty_pending_d;
         pwm_q          <= pwm_d;
         period_end_q   <= period_end_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_end   = period_end_q;
   assign duty_pending = duty_pending_q;

endmodule : pwm_duty_gen
